// File: rtl/sap1_control_unit_pkg.sv
// sap1_control_unit_pkg: shared opcodes, T-state indices, control-word layout and decoder
package sap1_control_unit_pkg;

    localparam int T_STATES = 6;
    localparam int OPCODE_W = 4;

    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_AND = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_OR  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_XOR = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_NOT = 4'b0110;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    localparam int CW_W  = 17;
    localparam int C_CP  = 16;
    localparam int C_EP  = 15;
    localparam int C_LM  = 14;
    localparam int C_CE  = 13;
    localparam int C_LI  = 12;
    localparam int C_EI  = 11;
    localparam int C_LA  = 10;
    localparam int C_EA  = 9;
    localparam int C_LB  = 8;
    localparam int C_LO  = 7;
    localparam int C_EU  = 6;
    localparam int C_ADD = 5;
    localparam int C_SUB = 4;
    localparam int C_AND = 3;
    localparam int C_OR  = 2;
    localparam int C_XOR = 1;
    localparam int C_NOT = 0;

    // Ungated control word for one T-state / opcode pair
    function automatic logic [CW_W-1:0] decode(input logic [T_STATES-1:0] t, input logic [OPCODE_W-1:0] op);
        logic [CW_W-1:0] c;
        logic alu2;
        c = '0;
        alu2 = (op >= OP_ADD) && (op <= OP_XOR);
        if (t[T1]) begin c[C_EP] = 1'b1; c[C_LM] = 1'b1; end
        if (t[T2]) c[C_CP] = 1'b1;
        if (t[T3]) begin c[C_CE] = 1'b1; c[C_LI] = 1'b1; end
        if (t[T4]) begin
            if (op == OP_LDA || alu2) begin c[C_EI] = 1'b1; c[C_LM] = 1'b1; end
            else if (op == OP_NOT) begin c[C_EU] = 1'b1; c[C_NOT] = 1'b1; c[C_LA] = 1'b1; end
            else if (op == OP_OUT) begin c[C_EA] = 1'b1; c[C_LO] = 1'b1; end
        end
        if (t[T5]) begin
            if (op == OP_LDA) begin c[C_CE] = 1'b1; c[C_LA] = 1'b1; end
            else if (alu2) begin c[C_CE] = 1'b1; c[C_LB] = 1'b1; end
        end
        if (t[T6] && alu2) begin
            c[C_EU]  = 1'b1;
            c[C_LA]  = 1'b1;
            c[C_ADD] = op == OP_ADD;
            c[C_SUB] = op == OP_SUB;
            c[C_AND] = op == OP_AND;
            c[C_OR]  = op == OP_OR;
            c[C_XOR] = op == OP_XOR;
        end
        return c;
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: one-hot T-state ring, T1 after reset, rotates left on adv
module sap1_ring_counter
    import sap1_control_unit_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic                adv,
    output logic [T_STATES-1:0] tstate
);

    // Rotate one position per advance; T6 wraps back to T1
    always_ff @(posedge clk or posedge clr)
        if (clr) tstate <= T_STATES'(1);
        else if (adv) tstate <= {tstate[T_STATES-2:0], tstate[T_STATES-1]};

endmodule

// File: rtl/sap1_control_unit.sv
// sap1_control_unit: SAP-1 T-state sequencer, opcode decoder and halt flag
module sap1_control_unit
    import sap1_control_unit_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic                step,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [T_STATES-1:0] tstate,
    output logic                halted,
    output logic                Cp,
    output logic                Ep,
    output logic                Lm,
    output logic                Ce,
    output logic                Li,
    output logic                Ei,
    output logic                La,
    output logic                Ea,
    output logic                Lb,
    output logic                Lo,
    output logic                Eu,
    output logic                Add,
    output logic                Sub,
    output logic                AndOp,
    output logic                OrOp,
    output logic                XorOp,
    output logic                NotOp
);

    logic            req;
    logic            hlt_now;
    logic [CW_W-1:0] cw;

    assign req     = !halted && (run || step);
    assign hlt_now = req && tstate[T4] && opcode == OP_HLT;

    // HLT in T4 freezes the ring there instead of advancing to T5
    sap1_ring_counter u_ring (
        .clk    (clk),
        .clr    (clr),
        .adv    (req && !hlt_now),
        .tstate (tstate)
    );

    // Halt flag set on the T4 edge of HLT; only clr clears it
    always_ff @(posedge clk or posedge clr)
        if (clr) halted <= 1'b0;
        else if (hlt_now) halted <= 1'b1;

    // Controls are silenced combinationally by clr and while halted
    always_comb cw = (clr || halted) ? '0 : decode(tstate, opcode);

    assign {Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Lb, Lo, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp} = cw;

endmodule

// File: tb/tb_sap1_control_unit.sv
// tb_sap1_control_unit: directed and randomized checks of the SAP-1 control sequencer
module tb_sap1_control_unit;

    localparam logic [16:0] CP  = 17'h1_0000;
    localparam logic [16:0] EP  = 17'h0_8000;
    localparam logic [16:0] LM  = 17'h0_4000;
    localparam logic [16:0] CE  = 17'h0_2000;
    localparam logic [16:0] LI  = 17'h0_1000;
    localparam logic [16:0] EI  = 17'h0_0800;
    localparam logic [16:0] LA  = 17'h0_0400;
    localparam logic [16:0] EA  = 17'h0_0200;
    localparam logic [16:0] LB  = 17'h0_0100;
    localparam logic [16:0] LO  = 17'h0_0080;
    localparam logic [16:0] EU  = 17'h0_0040;
    localparam logic [16:0] ADD = 17'h0_0020;
    localparam logic [16:0] SUB = 17'h0_0010;
    localparam logic [16:0] ANDO = 17'h0_0008;
    localparam logic [16:0] ORO = 17'h0_0004;
    localparam logic [16:0] XORO = 17'h0_0002;
    localparam logic [16:0] NOTO = 17'h0_0001;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] opcode = 4'b0001;
    logic [5:0] tstate;
    logic       halted;
    logic Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Lb, Lo, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp;
    logic [16:0] ctl;
    int total = 0;
    int passed = 0;

    assign ctl = {Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Lb, Lo, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp};

    always #5 clk = ~clk;

    sap1_control_unit dut (
        .clk(clk), .clr(clr), .run(run), .step(step), .opcode(opcode),
        .tstate(tstate), .halted(halted),
        .Cp(Cp), .Ep(Ep), .Lm(Lm), .Ce(Ce), .Li(Li), .Ei(Ei), .La(La), .Ea(Ea),
        .Lb(Lb), .Lo(Lo), .Eu(Eu), .Add(Add), .Sub(Sub), .AndOp(AndOp),
        .OrOp(OrOp), .XorOp(XorOp), .NotOp(NotOp)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        #1;
        clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        run = 1'b1;
        opcode = 4'b0001;
        @(negedge clk);
        clr = 1'b0;
        tick(); tick(); tick();
        clr = 1'b1;
        #1;
        total++; if (tstate !== 6'b000001) $display("FAIL reset_tstate got %b exp 000001", tstate); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else passed++;
        total++; if (ctl !== 17'h0) $display("FAIL reset_ctl got %h exp 0", ctl); else passed++;
        tick();
        total++; if (tstate !== 6'b000001) $display("FAIL reset_hold_tstate got %b exp 000001", tstate); else passed++;
        clr = 1'b0;
        #1;
        total++; if (ctl !== (EP | LM)) $display("FAIL release_ctl got %h exp %h", ctl, EP | LM); else passed++;
        total++; if (tstate !== 6'b000001) $display("FAIL release_tstate got %b exp 000001", tstate); else passed++;
    endtask

    task automatic test_add();
        logic [16:0] exp_ctl [6];
        exp_ctl = '{EP | LM, CP, CE | LI, EI | LM, CE | LB, EU | ADD | LA};
        for (int i = 0; i < 7; i++) begin
            total++; if (tstate !== 6'(1 << (i % 6))) $display("FAIL add_tstate%0d got %b exp %b", i, tstate, 6'(1 << (i % 6))); else passed++;
            total++; if (ctl !== exp_ctl[i % 6]) $display("FAIL add_ctl%0d got %h exp %h", i, ctl, exp_ctl[i % 6]); else passed++;
            tick();
        end
    endtask

    task automatic test_sweep();
        logic [3:0]  ops [8];
        logic [16:0] exp_ctl [6];
        ops = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
        for (int k = 0; k < 8; k++) begin
            exp_ctl = '{EP | LM, CP, CE | LI, 17'h0, 17'h0, 17'h0};
            case (ops[k])
                4'h0: begin exp_ctl[3] = EI | LM; exp_ctl[4] = CE | LA; end
                4'h2: begin exp_ctl[3] = EI | LM; exp_ctl[4] = CE | LB; exp_ctl[5] = EU | LA | SUB; end
                4'h3: begin exp_ctl[3] = EI | LM; exp_ctl[4] = CE | LB; exp_ctl[5] = EU | LA | ANDO; end
                4'h4: begin exp_ctl[3] = EI | LM; exp_ctl[4] = CE | LB; exp_ctl[5] = EU | LA | ORO; end
                4'h5: begin exp_ctl[3] = EI | LM; exp_ctl[4] = CE | LB; exp_ctl[5] = EU | LA | XORO; end
                4'h6: exp_ctl[3] = EU | NOTO | LA;
                4'hE: exp_ctl[3] = EA | LO;
                default: ;
            endcase
            opcode = ops[k];
            run = 1'b1;
            pulse_clr();
            for (int i = 0; i < 6; i++) begin
                total++; if (ctl !== exp_ctl[i]) $display("FAIL sweep_op%h_t%0d got %h exp %h", ops[k], i + 1, ctl, exp_ctl[i]); else passed++;
                tick();
            end
        end
    endtask

    task automatic test_hlt();
        opcode = 4'hF;
        run = 1'b1;
        pulse_clr();
        tick(); tick(); tick();
        total++; if (tstate !== 6'b001000) $display("FAIL hlt_t4_tstate got %b exp 001000", tstate); else passed++;
        total++; if (ctl !== 17'h0) $display("FAIL hlt_t4_ctl got %h exp 0", ctl); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL hlt_t4_halted got %b exp 0", halted); else passed++;
        tick();
        total++; if (halted !== 1'b1) $display("FAIL hlt_set got %b exp 1", halted); else passed++;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) opcode = 4'h1;
            tick();
            total++; if (tstate !== 6'b001000 || ctl !== 17'h0 || halted !== 1'b1)
                $display("FAIL hlt_hold%0d got tstate=%b ctl=%h halted=%b exp 001000/0/1", i, tstate, ctl, halted); else passed++;
        end
        pulse_clr();
        total++; if (halted !== 1'b0 || tstate !== 6'b000001) $display("FAIL hlt_clr got halted=%b tstate=%b exp 0/000001", halted, tstate); else passed++;
    endtask

    task automatic test_step();
        run = 1'b0;
        step = 1'b0;
        opcode = 4'h1;
        pulse_clr();
        tick(); tick();
        total++; if (tstate !== 6'b000001) $display("FAIL step_idle got %b exp 000001", tstate); else passed++;
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            total++; if (tstate !== 6'(1 << k)) $display("FAIL step%0d got %b exp %b", k, tstate, 6'(1 << k)); else passed++;
            tick(); tick();
            total++; if (tstate !== 6'(1 << k)) $display("FAIL step_gap%0d got %b exp %b", k, tstate, 6'(1 << k)); else passed++;
        end
        run = 1'b1;
        step = 1'b1;
        tick();
        total++; if (tstate !== 6'b010000) $display("FAIL run_and_step got %b exp 010000", tstate); else passed++;
        run = 1'b0;
        tick(); tick();
        step = 1'b0;
        total++; if (tstate !== 6'b000001) $display("FAIL step_held got %b exp 000001", tstate); else passed++;
    endtask

    task automatic test_random();
        int buses;
        int ops;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            clr = ($urandom_range(0, 31) == 0);
            run = 1'($urandom);
            step = 1'($urandom);
            opcode = 4'($urandom);
            #1;
            buses = int'(Ep) + int'(Ce) + int'(Ei) + int'(Ea) + int'(Eu);
            ops = int'(Add) + int'(Sub) + int'(AndOp) + int'(OrOp) + int'(XorOp) + int'(NotOp);
            total++;
            if (buses > 1 || ops > 1 || (ops != 0 && !Eu) || (Eu && ops != 1) || !$onehot(tstate) || ((clr || halted) && ctl != 17'h0))
                $display("FAIL invariant cycle %0d got buses=%0d ops=%0d Eu=%b tstate=%b ctl=%h exp legal", i, buses, ops, Eu, tstate, ctl);
            else passed++;
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sweep();
        test_hlt();
        test_step();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
